// File: rtl/band_scheduler_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the band scheduler.
package band_scheduler_pkg;

    localparam int DEF_NTAPS  = 31;
    localparam int DEF_NBANDS = 7;
    localparam int MAX_BANDS  = 7;

    localparam int X_W   = 8;
    localparam int C_W   = 10;
    localparam int P_W   = X_W + C_W;
    localparam int ACC_W = 24;
    localparam int Y_W   = 18;
    localparam int LVL_W = 8;

    localparam int RING_DEPTH = 32;
    localparam int PTR_W      = 5;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sd131071;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -24'sd131072;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    function automatic logic signed [Y_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] c;
        if (a > SAT_MAX)      c = SAT_MAX;
        else if (a < SAT_MIN) c = SAT_MIN;
        else                  c = a;
        return c[Y_W-1:0];
    endfunction

    // |y| >> 10 clipped to 8 bits; -131072 maps to 128 without overflow.
    function automatic logic [LVL_W-1:0] level(input logic signed [Y_W-1:0] y);
        logic [Y_W-1:0] mag;
        logic [Y_W-1:0] shifted;
        mag     = y[Y_W-1] ? Y_W'(-y) : Y_W'(y);
        shifted = mag >> 10;
        return (shifted > Y_W'(255)) ? LVL_W'(255) : shifted[LVL_W-1:0];
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above start.
    function automatic logic [3:0] find_band(input logic [MAX_BANDS-1:0] mask, input logic [3:0] start);
        logic [3:0] r;
        r = '0;
        for (int i = MAX_BANDS - 1; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_ring32.sv
// 32-entry sample history with write pointer and a combinational read by age offset.
module sample_ring32
    import band_scheduler_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic signed [X_W-1:0]   wr_data,
    input  logic [PTR_W-1:0]        rd_offset,
    output logic signed [X_W-1:0]   rd_data
);

    logic signed [X_W-1:0] mem [RING_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rd_addr;

    // NOTE: the history must read as silence after reset, so the storage is
    // reset as registers rather than left to power-up contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            for (int i = 0; i < RING_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + 1'b1;
        end
    end

    // Offset 0 is the newest sample; the 5-bit subtraction wraps mod 32.
    assign rd_addr = wptr - PTR_W'(1) - rd_offset;
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/band_scheduler.sv
// Time-multiplexes one MAC across up to seven FIR band filters per input sample.
module band_scheduler
    import band_scheduler_pkg::*;
#(
    parameter int NTAPS  = DEF_NTAPS,
    parameter int NBANDS = DEF_NBANDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready,
    input  logic signed [X_W-1:0] x_in,
    input  logic [7:0]            controls,
    input  logic signed [C_W-1:0] coeff,
    output logic [4:0]            tap_index,
    output logic [2:0]            band_sel,
    output logic signed [Y_W-1:0] band_y,
    output logic [2:0]            band_num,
    output logic                  band_valid,
    output logic                  frame_done,
    output logic [LVL_W-1:0]      freq1,
    output logic [LVL_W-1:0]      freq2,
    output logic [LVL_W-1:0]      freq3,
    output logic [LVL_W-1:0]      freq4,
    output logic [LVL_W-1:0]      freq5,
    output logic [LVL_W-1:0]      freq6,
    output logic [LVL_W-1:0]      freq7,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [MAX_BANDS-1:0] BAND_MASK = MAX_BANDS'((1 << NBANDS) - 1);

    state_t                  state, state_nx;
    logic [4:0]              k;
    logic [2:0]              band;
    logic [MAX_BANDS-1:0]    mask;
    logic signed [ACC_W-1:0] acc;
    logic [LVL_W-1:0]        freq_q [MAX_BANDS];

    logic [MAX_BANDS-1:0]    en_mask;
    logic [3:0]              first_hit, next_hit;
    logic signed [X_W-1:0]   x_k;
    logic signed [P_W-1:0]   product;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [Y_W-1:0]   y_sat;
    logic                    accept;
    logic                    unused_ctrl;

    assign unused_ctrl = controls[7];
    assign en_mask     = controls[MAX_BANDS-1:0] & BAND_MASK;
    assign first_hit   = find_band(en_mask, 4'd0);
    assign next_hit    = find_band(mask, {1'b0, band} + 4'd1);
    assign accept      = ready && (state == ST_IDLE);

    sample_ring32 u_ring (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (accept),
        .wr_data   (x_in),
        .rd_offset (k),
        .rd_data   (x_k)
    );

    assign product  = coeff * x_k;
    assign prod_ext = {{(ACC_W-P_W){product[P_W-1]}}, product};
    assign y_sat    = saturate(acc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (ready && (en_mask != '0)) state_nx = ST_MAC;
            ST_MAC:  if (k == 5'(NTAPS - 1))      state_nx = ST_DUMP;
            ST_DUMP: state_nx = next_hit[3] ? ST_MAC : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k          <= '0;
            band       <= '0;
            mask       <= '0;
            acc        <= '0;
            band_y     <= '0;
            band_num   <= '0;
            band_valid <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < MAX_BANDS; i++) freq_q[i] <= '0;
        end else begin
            band_valid <= 1'b0;
            frame_done <= 1'b0;
            if (ready && (state != ST_IDLE)) overrun <= 1'b1;
            case (state)
                ST_IDLE: if (ready) begin
                    mask <= en_mask;
                    band <= first_hit[2:0];
                    k    <= '0;
                    acc  <= '0;
                    for (int i = 0; i < MAX_BANDS; i++) begin
                        if (!en_mask[i]) freq_q[i] <= '0;
                    end
                    if (en_mask == '0) frame_done <= 1'b1;
                end
                ST_MAC: begin
                    acc <= acc + prod_ext;
                    if (k != 5'(NTAPS - 1)) k <= k + 5'd1;
                end
                ST_DUMP: begin
                    band_y       <= y_sat;
                    band_num     <= band;
                    band_valid   <= 1'b1;
                    freq_q[band] <= level(y_sat);
                    k            <= '0;
                    acc          <= '0;
                    if (next_hit[3]) band       <= next_hit[2:0];
                    else             frame_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign tap_index = busy ? k : 5'd0;
    assign band_sel  = busy ? band : 3'd0;

    assign freq1 = freq_q[0];
    assign freq2 = freq_q[1];
    assign freq3 = freq_q[2];
    assign freq4 = freq_q[3];
    assign freq5 = freq_q[4];
    assign freq6 = freq_q[5];
    assign freq7 = freq_q[6];

endmodule

// File: tb/tb_band_scheduler.sv
// Directed bench for band_scheduler: impulse, DC, saturation, masks, overrun, mid-frame reset.
module tb_band_scheduler;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ready = 1'b0;
    logic signed [7:0] x_in = '0;
    logic [7:0]        controls = '0;
    logic signed [9:0] coeff;
    logic [4:0]        tap_index;
    logic [2:0]        band_sel;
    logic signed [17:0] band_y;
    logic [2:0]        band_num;
    logic              band_valid, frame_done, busy, overrun;
    logic [7:0]        freq1, freq2, freq3, freq4, freq5, freq6, freq7;

    int cyc = 0;
    int mode = 0;
    int total = 0;
    int bad = 0;

    band_scheduler dut (
        .clock(clock), .reset(reset), .ready(ready), .x_in(x_in),
        .controls(controls), .coeff(coeff), .tap_index(tap_index),
        .band_sel(band_sel), .band_y(band_y), .band_num(band_num),
        .band_valid(band_valid), .frame_done(frame_done),
        .freq1(freq1), .freq2(freq2), .freq3(freq3), .freq4(freq4),
        .freq5(freq5), .freq6(freq6), .freq7(freq7),
        .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Coefficient ROM model selected per test.
    always_comb begin
        case (mode)
            0:       coeff = 10'(int'(tap_index) + 1);
            1:       coeff = 10'sd10;
            2:       coeff = 10'sd511;
            3:       coeff = -10'sd512;
            default: coeff = 10'(32 * int'(band_sel) + int'(tap_index) + 1);
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ready is high during cycle n; returns with the strobe already captured.
    task automatic send(input int x, input logic [7:0] ctl, output int n);
        @(posedge clock);
        #1;
        ready    = 1'b1;
        x_in     = 8'(x);
        controls = ctl;
        n        = cyc;
        @(posedge clock);
        #1;
        ready    = 1'b0;
        controls = 8'hFF;
    endtask

    task automatic wait_valid(output int y, output int num, output int at, output int fd);
        bit got = 1'b0;
        y = 0; num = -1; at = -1; fd = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clock);
            if (band_valid) begin
                got = 1'b1;
                y   = int'(band_y);
                num = int'(band_num);
                at  = cyc;
                fd  = int'(frame_done);
            end
        end
        if (!got) check("band_valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n2, y, num, at, fd, pulses;

        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_band_valid", band_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_band_y", int'(band_y), 0);
        check("rst_freq1", freq1, 0);
        check("rst_freq7", freq7, 0);
        check("rst_tap_index", tap_index, 0);
        check("rst_band_sel", band_sel, 0);
        #1 reset = 1'b1;

        // Impulse through band 0: result walks the coefficient table.
        mode = 0;
        for (int m = 0; m < 32; m++) begin
            send((m == 0) ? 1 : 0, 8'h01, n);
            wait_valid(y, num, at, fd);
            check($sformatf("impulse_y_m%0d", m), y, (m < 31) ? m + 1 : 0);
            if (m == 0) begin
                check("impulse_latency", at, n + 33);
                check("impulse_band_num", num, 0);
                check("impulse_frame_done", fd, 1);
            end
        end
        @(negedge clock);
        check("idle_busy", busy, 0);

        // DC: full window of 100 with coefficient 10.
        mode = 1;
        for (int i = 0; i < 31; i++) begin
            send(100, 8'h01, n);
            wait_valid(y, num, at, fd);
        end
        check("dc_y", y, 31000);
        check("dc_freq1", freq1, 30);

        // Positive and negative saturation.
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            send(127, 8'h01, n);
            wait_valid(y, num, at, fd);
        end
        check("sat_pos_y", y, 131071);
        check("sat_pos_freq1", freq1, 127);
        check("sat_disabled_freq2", freq2, 0);
        mode = 3;
        send(127, 8'h01, n);
        wait_valid(y, num, at, fd);
        check("sat_neg_y", y, -131072);
        check("sat_neg_freq1", freq1, 128);

        // Zero mask writes the ring and pulses frame_done only.
        do_reset();
        mode = 4;
        send(1, 8'h80, n);
        @(negedge clock);
        check("mask0_frame_done", frame_done, 1);
        check("mask0_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (band_valid) pulses++;
        end
        check("mask0_no_valid", pulses, 0);

        // Mask 0x05: bands 0 and 2, second one carries frame_done.
        send(0, 8'h05, n);
        wait_valid(y, num, at, fd);
        check("m05_b0_y", y, 2);
        check("m05_b0_num", num, 0);
        check("m05_b0_at", at, n + 33);
        check("m05_b0_fd", fd, 0);
        wait_valid(y, num, at, fd);
        check("m05_b2_y", y, 66);
        check("m05_b2_num", num, 2);
        check("m05_b2_at", at, n + 65);
        check("m05_b2_fd", fd, 1);
        check("m05_freq2", freq2, 0);

        // Overrun: second strobe while busy is dropped.
        do_reset();
        mode = 0;
        send(1, 8'h01, n);
        repeat (3) @(posedge clock);
        send(50, 8'h01, n2);
        wait_valid(y, num, at, fd);
        check("ovr_y", y, 1);
        check("ovr_at", at, n + 33);
        check("ovr_flag", overrun, 1);
        send(0, 8'h01, n);
        wait_valid(y, num, at, fd);
        check("ovr_ring_unchanged", y, 2);

        // All seven bands: one result per 32 cycles, last at n+225.
        send(0, 8'h7F, n);
        for (int b = 0; b < 7; b++) begin
            wait_valid(y, num, at, fd);
            check($sformatf("all_b%0d_num", b), num, b);
            check($sformatf("all_b%0d_y", b), y, 3);
        end
        check("all_last_at", at, n + 225);
        check("all_last_fd", fd, 1);
        check("all_overrun_sticky", overrun, 1);

        // Reset in the middle of the second band.
        send(1, 8'h7F, n);
        wait_valid(y, num, at, fd);
        while (cyc < n + 40) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_band_y", int'(band_y), 0);
        check("midrst_freq1", freq1, 0);
        check("midrst_band_sel", band_sel, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (band_valid || frame_done) pulses++;
        end
        check("midrst_no_pulses", pulses, 0);
        send(1, 8'h01, n);
        wait_valid(y, num, at, fd);
        check("midrst_restart_y", y, 1);
        check("midrst_restart_at", at, n + 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
